hazard_debug_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage core. It sits beside decode and execute and produces the F/D stall and D/E flush controls plus the E-stage forwarding selects. It consumes the register addresses that decode exports for hazard detection. It also adds a debug run-control FSM (halt, drain, single-step, resume) that freezes fetch and drains the pipeline so that the architectural register state is stable while halted.

---
 rtl/hazard_debug_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_debug_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_debug_ctrl.sv
// Hazard and debug run-control unit for the 5-stage core.
// It produces the F/D stalls, the D/E flushes, the E-stage forwarding selects and the halt/drain/step sequencing.
module hazard_debug_ctrl #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_addr_d_i,
  input  logic [4:0] rs2_addr_d_i,
  input  logic [4:0] rs1_addr_e_i,
  input  logic [4:0] rs2_addr_e_i,
  input  logic [4:0] rd_addr_e_i,
  input  logic [1:0] result_src_e_i,
  input  logic       pc_src_e_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_addr_m_i,
  input  logic       reg_write_w_i,
  input  logic [4:0] rd_addr_w_i,
  input  logic       halt_req_i,
  input  logic       resume_req_i,
  input  logic       step_req_i,
  output logic       stall_f_o,
  output logic       stall_d_o,
  output logic       flush_d_o,
  output logic       flush_e_o,
  output logic [1:0] forward_a_e_o,
  output logic [1:0] forward_b_e_o,
  output logic       halted_o
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             lwstall;

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign forward_a_e_o = fwd_sel(rs1_addr_e_i, reg_write_m_i, rd_addr_m_i,
                                 reg_write_w_i, rd_addr_w_i);
  assign forward_b_e_o = fwd_sel(rs2_addr_e_i, reg_write_m_i, rd_addr_m_i,
                                 reg_write_w_i, rd_addr_w_i);

  assign lwstall = (result_src_e_i == 2'b01) && (rd_addr_e_i != 5'd0) &&
                   ((rd_addr_e_i == rs1_addr_d_i) || (rd_addr_e_i == rs2_addr_d_i));

  assign halted_o = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;

    unique case (state_q)
      RUN, STEP: begin
        stall_f_o = lwstall;
        stall_d_o = lwstall;
        flush_d_o = pc_src_e_i;
        flush_e_o = lwstall | pc_src_e_i;
        if (state_q == STEP) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
        end else if (halt_req_i && !lwstall && !pc_src_e_i) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
        end
      end

      // Fetch is frozen, except that a redirect must still reach the PC.
      DRAIN: begin
        stall_f_o = 1'b1;
        flush_d_o = 1'b1;
        if (pc_src_e_i) begin
          stall_f_o = 1'b0;
          flush_e_o = 1'b1;
        end
        if (lwstall) begin
          stall_f_o = 1'b1;
          stall_d_o = 1'b1;
          flush_d_o = 1'b0;
          flush_e_o = 1'b1;
        end else if (cnt_q == '0) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      HALTED: begin
        stall_f_o = 1'b1;
        flush_d_o = 1'b1;
        if (resume_req_i) begin
          state_d  = RUN;
          halted_d = 1'b0;
        end else if (step_req_i) begin
          state_d  = STEP;
          halted_d = 1'b0;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_debug_ctrl.sv
// Self-checking bench for hazard_debug_ctrl: directed steps followed by random cycles.
// The reference model below tracks the run-control mode and the remaining drain length.
module tb_hazard_debug_ctrl;

  localparam int D = 4;

  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALTED = 2;
  localparam int M_STEP   = 3;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e, rd_addr_e;
  logic [1:0] result_src_e;
  logic       pc_src_e;
  logic       reg_write_m, reg_write_w;
  logic [4:0] rd_addr_m, rd_addr_w;
  logic       halt_req, resume_req, step_req;
  logic       stall_f_o, stall_d_o, flush_d_o, flush_e_o, halted_o;
  logic [1:0] forward_a_e_o, forward_b_e_o;

  int errors = 0;
  int checks = 0;
  int accepts = 0;

  int m_mode = M_RUN;
  int m_left = 0;
  bit m_halted = 1'b0;

  hazard_debug_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_addr_d_i   (rs1_addr_d),
    .rs2_addr_d_i   (rs2_addr_d),
    .rs1_addr_e_i   (rs1_addr_e),
    .rs2_addr_e_i   (rs2_addr_e),
    .rd_addr_e_i    (rd_addr_e),
    .result_src_e_i (result_src_e),
    .pc_src_e_i     (pc_src_e),
    .reg_write_m_i  (reg_write_m),
    .rd_addr_m_i    (rd_addr_m),
    .reg_write_w_i  (reg_write_w),
    .rd_addr_w_i    (rd_addr_w),
    .halt_req_i     (halt_req),
    .resume_req_i   (resume_req),
    .step_req_i     (step_req),
    .stall_f_o      (stall_f_o),
    .stall_d_o      (stall_d_o),
    .flush_d_o      (flush_d_o),
    .flush_e_o      (flush_e_o),
    .forward_a_e_o  (forward_a_e_o),
    .forward_b_e_o  (forward_b_e_o),
    .halted_o       (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (reg_write_m && rd_addr_m != 0 && rd_addr_m == rs) return 2'b10;
    if (reg_write_w && rd_addr_w != 0 && rd_addr_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_lw();
    return (result_src_e == 2'b01) && (rd_addr_e != 0) &&
           (rd_addr_e == rs1_addr_d || rd_addr_e == rs2_addr_d);
  endfunction

  task automatic checkOutput();
    bit lw, sf, sd, fd, fe;
    lw = exp_lw();
    sf = 0; sd = 0; fd = 0; fe = 0;
    if (m_mode == M_RUN || m_mode == M_STEP) begin
      sf = lw; sd = lw; fd = pc_src_e; fe = lw | pc_src_e;
    end else if (m_mode == M_DRAIN) begin
      if (lw)            begin sf = 1; sd = 1; fd = 0; fe = 1; end
      else if (pc_src_e) begin sf = 0; sd = 0; fd = 1; fe = 1; end
      else               begin sf = 1; sd = 0; fd = 1; fe = 0; end
    end else begin
      sf = 1; sd = 0; fd = 1; fe = 0;
    end
    chk("stall_f", {7'd0, stall_f_o}, {7'd0, sf});
    chk("stall_d", {7'd0, stall_d_o}, {7'd0, sd});
    chk("flush_d", {7'd0, flush_d_o}, {7'd0, fd});
    chk("flush_e", {7'd0, flush_e_o}, {7'd0, fe});
    chk("forward_a", {6'd0, forward_a_e_o}, {6'd0, exp_fwd(rs1_addr_e)});
    chk("forward_b", {6'd0, forward_b_e_o}, {6'd0, exp_fwd(rs2_addr_e)});
    chk("halted", {7'd0, halted_o}, {7'd0, m_halted});
  endtask

  // Drain length counts the non-stalled drain cycles still owed: D bubbles plus the entry cycle.
  task automatic modelTick();
    bit lw;
    lw = exp_lw();
    case (m_mode)
      M_RUN: if (halt_req && !lw && !pc_src_e) begin m_mode = M_DRAIN; m_left = D + 1; end
      M_DRAIN: if (!lw) begin
        m_left--;
        if (m_left == 0) begin m_mode = M_HALTED; m_halted = 1; end
      end
      M_HALTED: begin
        if (resume_req)    begin m_mode = M_RUN;  m_halted = 0; end
        else if (step_req) begin m_mode = M_STEP; m_halted = 0; end
      end
      default: begin m_mode = M_DRAIN; m_left = D + 1; end
    endcase
  endtask

  task automatic modelReset();
    m_mode = M_RUN; m_left = 0; m_halted = 0;
  endtask

  task automatic clearInputs();
    rs1_addr_d = 0; rs2_addr_d = 0; rs1_addr_e = 0; rs2_addr_e = 0; rd_addr_e = 0;
    result_src_e = 0; pc_src_e = 0; reg_write_m = 0; rd_addr_m = 0;
    reg_write_w = 0; rd_addr_w = 0; halt_req = 0; resume_req = 0; step_req = 0;
  endtask

  // Entered and left at posedge+1: check outputs, then advance one clock.
  task automatic applyStimulus();
    #2;
    checkOutput();
    if (!stall_d_o && !flush_d_o) accepts++;
    @(posedge clk);
    modelTick();
    #1;
  endtask

  task automatic asyncReset();
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitHalted(input string tag);
    int n;
    n = 0;
    while (halted_o !== 1'b1 && n < 20) begin
      applyStimulus();
      n++;
    end
    chk(tag, {7'd0, halted_o}, 8'd1);
  endtask

  initial begin
    int n;
    bit seen;
    clearInputs();
    rst_n = 1'b0;
    #12;
    chk("reset_halted", {7'd0, halted_o}, 8'd0);
    chk("reset_stall_f", {7'd0, stall_f_o}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] forwarding");
    rs1_addr_e = 5; reg_write_m = 1; rd_addr_m = 5; reg_write_w = 1; rd_addr_w = 5;
    #1 chk("fwd_m_prio", {6'd0, forward_a_e_o}, 8'd2);
    applyStimulus();
    reg_write_m = 0;
    #1 chk("fwd_w", {6'd0, forward_a_e_o}, 8'd1);
    applyStimulus();
    reg_write_m = 1; rd_addr_m = 0; rd_addr_w = 0;
    #1 chk("fwd_x0", {6'd0, forward_a_e_o}, 8'd0);
    applyStimulus();
    clearInputs();

    $display("[TB] load-use and branch");
    result_src_e = 2'b01; rd_addr_e = 7; rs2_addr_d = 7;
    #1 chk("lw_stall_d", {7'd0, stall_d_o}, 8'd1);
    applyStimulus();
    rd_addr_e = 0; rs2_addr_d = 0;
    #1 chk("lw_x0", {7'd0, stall_f_o}, 8'd0);
    applyStimulus();
    clearInputs();
    pc_src_e = 1;
    #1 chk("branch_flush_e", {7'd0, flush_e_o}, 8'd1);
    applyStimulus();
    clearInputs();

    $display("[TB] halt latency");
    halt_req = 1;
    applyStimulus();
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      applyStimulus();
      n++;
      if (halted_o === 1'b1) seen = 1;
    end
    chk("halt_latency", 8'(n), 8'(D + 1));
    halt_req = 0;

    $display("[TB] single step");
    step_req = 1;
    accepts = 0;
    applyStimulus();
    step_req = 0;
    waitHalted("step_rehalt");
    chk("step_one_instr", 8'(accepts), 8'd1);

    resume_req = 1; step_req = 1;
    applyStimulus();
    clearInputs();
    chk("resume_prio", {7'd0, halted_o}, 8'd0);
    #1 chk("resume_run", {7'd0, stall_f_o}, 8'd0);
    applyStimulus();

    $display("[TB] halt deferral and redirect");
    halt_req = 1; result_src_e = 2'b01; rd_addr_e = 7; rs1_addr_d = 7;
    applyStimulus();
    result_src_e = 0; rd_addr_e = 0; rs1_addr_d = 0;
    #1 chk("defer_still_run", {7'd0, stall_f_o}, 8'd0);
    applyStimulus();
    #1 chk("drain_entered", {7'd0, stall_f_o}, 8'd1);
    applyStimulus();
    pc_src_e = 1;
    #1 chk("drain_redirect", {7'd0, stall_f_o}, 8'd0);
    applyStimulus();
    pc_src_e = 0;
    waitHalted("redirect_halt");
    halt_req = 0;

    $display("[TB] async reset");
    #1;
    asyncReset();
    halt_req = 1;
    applyStimulus();
    applyStimulus();
    asyncReset();
    chk("reset_mid_drain", {7'd0, stall_f_o}, 8'd0);

    $display("[TB] random");
    for (int i = 0; i < 800; i++) begin
      rs1_addr_d   = 5'($urandom_range(0, 3));
      rs2_addr_d   = 5'($urandom_range(0, 3));
      rs1_addr_e   = 5'($urandom_range(0, 3));
      rs2_addr_e   = 5'($urandom_range(0, 3));
      rd_addr_e    = 5'($urandom_range(0, 3));
      result_src_e = 2'($urandom_range(0, 3));
      pc_src_e     = ($urandom_range(0, 5) == 0);
      reg_write_m  = 1'($urandom_range(0, 1));
      rd_addr_m    = 5'($urandom_range(0, 3));
      reg_write_w  = 1'($urandom_range(0, 1));
      rd_addr_w    = 5'($urandom_range(0, 3));
      halt_req     = ($urandom_range(0, 2) == 0);
      resume_req   = ($urandom_range(0, 4) == 0);
      step_req     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) asyncReset();
      else applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
